fifo_rd_stream: RTL and testbench

Read-side consumer for the team's dual-clock FIFO, instantiated in the FIFO's read clock domain. It drives the FIFO read port: `fifo_rd_en`, registered `fifo_rd_data` with 1-cycle latency, and the lagging `fifo_empty` / `fifo_almost_empty` flags. It re-presents the words as a full-throughput valid/ready stream through a 3-entry output buffer. A purge sequence discards buffered and queued words on request.

---
 rtl/fifo_rd_stream.sv | 126 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO: issues reads and re-presents words as a valid/ready
// stream through a 3-entry buffer, with a purge sequence. Define FIFO_RD_STREAM_CNT_EN for xfer_cnt.
module fifo_rd_stream #(
  parameter int DSIZE  = 8,
  parameter int ALMOST = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [DSIZE-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready,
  input  logic             purge,
  output logic             purge_done,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_PURGE, ST_SETTLE, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic             settle_q, settle_d;
  logic             rd_q, rd_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [DSIZE-1:0] buf_q [3];
  logic [DSIZE-1:0] buf_d [3];
  logic             rd_room;
  logic             push;
  logic             pop;

  if (ALMOST < 2) begin : g_almost_check
    $error("fifo_rd_stream: ALMOST must be at least 2");
  end

  // The FIFO flags lag one read, so a read right after a read is only safe above almost-empty.
  always_comb begin
    rd_room = 1'b0;
    case (state_q)
      ST_RUN:   rd_room = ({1'b0, buf_cnt_q} + {2'b00, rd_q}) < 3'd3;
      ST_PURGE: rd_room = 1'b1;
      default:  rd_room = 1'b0;
    endcase
    fifo_rd_en = !fifo_empty && (!rd_q || !fifo_almost_empty) && rd_room;
  end

  assign out_valid  = (buf_cnt_q != 2'd0) && (state_q == ST_RUN);
  assign out_data   = buf_q[0];
  assign busy       = (state_q != ST_RUN);
  assign purge_done = (state_q == ST_DONE);
  assign pop        = out_valid && out_ready;
  assign push       = rd_q && (state_q == ST_RUN);
  assign rd_d       = fifo_rd_en;

  always_comb begin
    state_d  = state_q;
    settle_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (purge) state_d = ST_PURGE;
      end
      ST_PURGE: begin
        if (fifo_empty && !rd_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!fifo_empty)   state_d = ST_PURGE;
        else if (settle_q) state_d = ST_DONE;
        else               settle_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Head lives in entry 0; a pop shifts down before the captured word lands behind the survivors.
  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_d[1]  = buf_q[2];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (push) begin
      case (buf_cnt_d)
        2'd0:    buf_d[0] = fifo_rd_data;
        2'd1:    buf_d[1] = fifo_rd_data;
        default: buf_d[2] = fifo_rd_data;
      endcase
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
    if ((state_q == ST_RUN) && purge) buf_cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      settle_q  <= 1'b0;
      rd_q      <= 1'b0;
      buf_cnt_q <= 2'd0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      rd_q      <= rd_d;
      buf_cnt_q <= buf_cnt_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer_cnt_q + {15'd0, pop};
  assign xfer_cnt   = xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= 16'd0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end
`else
  assign xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO model with one-read-lagging flags feeds the DUT and a word
// scoreboard checks the stream order; xfer_cnt expectations follow FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;
  localparam int DSIZE  = 8;
  localparam int ALMOST = 3;

  typedef struct {
    bit purge;
    bit exp_busy;
    bit exp_done;
    bit exp_rd_en;
    bit exp_valid;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] fifo_rd_data = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_almost_empty = 1'b1;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             purge = 1'b0;
  logic             purge_done;
  logic             busy;
  logic [15:0]      xfer_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int hs_count = 0;
  int reads_total = 0;
  bit discarding = 1'b0;

  logic [DSIZE-1:0] fifo_mem [$];
  logic [DSIZE-1:0] pending [$];
  logic [DSIZE-1:0] got [$];
  int               got_cyc [$];

  logic             s_rd = 1'b0;
  logic             s_hs = 1'b0;
  logic [DSIZE-1:0] s_data = '0;
  logic             prev_hold = 1'b0;
  logic [DSIZE-1:0] prev_data = '0;

  fifo_rd_stream #(.DSIZE(DSIZE), .ALMOST(ALMOST)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .purge             (purge),
    .purge_done        (purge_done),
    .busy              (busy),
    .xfer_cnt          (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] expXfer();
`ifdef FIFO_RD_STREAM_CNT_EN
    return 32'(hs_count & 32'h0000_FFFF);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] gotAt(input int idx);
    if (got.size() > idx) return 32'(got[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  // Sample DUT outputs mid-cycle; the model below consumes them at the following edge.
  always @(negedge clk) begin
    cycle++;
    if (prev_hold) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", 32'(out_data), 32'(prev_data));
    end
    s_rd      = fifo_rd_en;
    s_hs      = out_valid && out_ready && !rst;
    s_data    = out_data;
    prev_hold = out_valid && !out_ready && !rst && !purge;
    prev_data = out_data;
  end

  // FIFO with registered read data and flags that reflect occupancy before the latest read.
  always @(posedge clk) begin
    if (s_hs) begin
      checkOutput("stream_word_has_source", 32'(pending.size() != 0), 32'd1);
      if (pending.size() != 0) begin
        checkOutput("stream_order", 32'(s_data), 32'(pending[0]));
        void'(pending.pop_front());
      end
      got.push_back(s_data);
      got_cyc.push_back(cycle);
      hs_count++;
    end
    fifo_empty        <= (fifo_mem.size() == 0);
    fifo_almost_empty <= (fifo_mem.size() <= ALMOST);
    if (s_rd) begin
      checkOutput("read_not_stale", 32'(fifo_mem.size() != 0), 32'd1);
      if (fifo_mem.size() != 0) begin
        fifo_rd_data <= fifo_mem[0];
        pending.push_back(fifo_mem[0]);
        void'(fifo_mem.pop_front());
        reads_total++;
      end
    end
    if (rst) begin
      pending.delete();
      hs_count = 0;
    end else if (discarding) begin
      pending.delete();
    end
  end

  task automatic applyStimulus(input bit r, input bit rdy, input bit pg);
    @(posedge clk);
    #1;
    rst       = r;
    out_ready = rdy;
    purge     = pg;
  endtask

  task automatic waitGot(input string name, input int n, input int budget, input bit rdy);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      applyStimulus(1'b0, rdy, 1'b0);
      k++;
    end
    @(negedge clk);
    checkOutput(name, 32'(got.size()), 32'(n));
  endtask

  task automatic waitDrain(input string name, input int budget);
    int k;
    k = 0;
    while (!(fifo_mem.size() == 0 && pending.size() == 0 && !out_valid) && k < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      k++;
    end
    checkOutput(name, 32'(fifo_mem.size() == 0 && pending.size() == 0 && !out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    int   t_rd, t_val, base, pulses, max_gap;
    bit   consec;

    vecs[0] = '{purge: 1'b1, exp_busy: 1'b0, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[1] = '{purge: 1'b0, exp_busy: 1'b1, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[2] = '{purge: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[3] = '{purge: 1'b0, exp_busy: 1'b1, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[4] = '{purge: 1'b0, exp_busy: 1'b1, exp_done: 1'b1, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[5] = '{purge: 1'b0, exp_busy: 1'b0, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};
    vecs[6] = '{purge: 1'b0, exp_busy: 1'b0, exp_done: 1'b0, exp_rd_en: 1'b0, exp_valid: 1'b0};

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_purge_done", 32'(purge_done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // Empty-FIFO purge: done exactly four cycles after the request, purge in SETTLE ignored.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, vecs[i].purge);
      @(negedge clk);
      checkOutput($sformatf("empty_purge_busy_%0d", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("empty_purge_done_%0d", i), 32'(purge_done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("empty_purge_rd_en_%0d", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
      checkOutput($sformatf("empty_purge_valid_%0d", i), 32'(out_valid), 32'(vecs[i].exp_valid));
    end

    got.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    fifo_mem.push_back(8'h11);
    fifo_mem.push_back(8'h22);
    fifo_mem.push_back(8'h33);
    t_rd  = -1;
    t_val = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      if (t_rd < 0 && fifo_rd_en) t_rd = i;
      if (t_val < 0 && out_valid) t_val = i;
    end
    checkOutput("first_read_seen", 32'(t_rd >= 0), 32'd1);
    checkOutput("first_valid_latency", 32'(t_val - t_rd), 32'd2);
    checkOutput("three_word_count", 32'(got.size()), 32'd3);
    checkOutput("three_word_0", gotAt(0), 32'h11);
    checkOutput("three_word_1", gotAt(1), 32'h22);
    checkOutput("three_word_2", gotAt(2), 32'h33);

    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 16; i++) fifo_mem.push_back(8'(8'h40 + i));
    waitGot("prefill16_count", 16, 80, 1'b1);
    consec  = 1'b1;
    max_gap = 0;
    for (int i = 1; i < got_cyc.size(); i++) begin
      if (i < 12 && got_cyc[i] - got_cyc[i-1] != 1) consec = 1'b0;
      if (got_cyc[i] - got_cyc[i-1] > max_gap) max_gap = got_cyc[i] - got_cyc[i-1];
    end
    checkOutput("prefill16_first12_back_to_back", 32'(consec), 32'd1);
    checkOutput("prefill16_gap_at_most_2", 32'(max_gap <= 2), 32'd1);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("prefill16_word_%0d", i), gotAt(i), 32'h40 + 32'(i));
`ifdef FIFO_RD_STREAM_CNT_EN
    checkOutput("prefill16_xfer_cnt", 32'(xfer_cnt), 32'd16);
`else
    checkOutput("prefill16_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif

    got.delete();
    applyStimulus(1'b0, 1'b0, 1'b0);
    base = reads_total;
    for (int i = 0; i < 8; i++) fifo_mem.push_back(8'(8'h80 + i));
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall_reads_issued", 32'(reads_total - base), 32'd3);
    checkOutput("stall_rd_en_low", 32'(fifo_rd_en), 32'd0);
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_head_word", 32'(out_data), 32'h80);
    waitGot("stall_release_count", 8, 40, 1'b1);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("stall_word_%0d", i), gotAt(i), 32'h80 + 32'(i));

    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) fifo_mem.push_back(8'(8'hC0 + i));
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("purge_pre_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    discarding = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("purge_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("purge_busy", 32'(busy), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (purge_done) begin
        pulses++;
        discarding = 1'b0;
      end
    end
    discarding = 1'b0;
    checkOutput("purge_done_pulses", 32'(pulses), 32'd1);
    checkOutput("purge_fifo_drained", 32'(fifo_mem.size()), 32'd0);
    checkOutput("purge_busy_cleared", 32'(busy), 32'd0);
    got.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    fifo_mem.push_back(8'hA5);
    waitGot("after_purge_count", 1, 20, 1'b1);
    checkOutput("after_purge_word", gotAt(0), 32'hA5);

    got.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) fifo_mem.push_back(8'(8'hE0 + i));
    waitGot("pre_reset_stream", 3, 20, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_out_data", 32'(out_data), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_purge_done", 32'(purge_done), 32'd0);
    checkOutput("midreset_xfer_cnt", 32'(xfer_cnt), 32'd0);
    waitDrain("midreset_drain", 60);
    checkOutput("midreset_words_dropped", 32'(got.size() < 12), 32'd1);
    checkOutput("midreset_last_word", gotAt(got.size() - 1), 32'hEB);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70), 1'b0);
      if ($urandom_range(0, 99) < 45) fifo_mem.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 99) < 8) begin
        for (int j = 0; j < 3; j++) fifo_mem.push_back(8'($urandom_range(0, 255)));
      end
    end
    waitDrain("random_drain", 300);
    checkOutput("random_xfer_cnt", 32'(xfer_cnt), expXfer());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
